// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode constants, class indices and decoded-entry type for the decode stage
package decode_pkg;

    localparam int NUM_CLASSES = 16;

    // Base ISA opcodes
    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_I_ALU  = 7'd19;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_SYSTEM = 7'd115;

    // Vector extension opcodes
    localparam logic [6:0] OP_VEC_R    = 7'd11;
    localparam logic [6:0] OP_S2V      = 7'd43;
    localparam logic [6:0] OP_V2S      = 7'd91;
    localparam logic [6:0] OP_VSTORE   = 7'd39;
    localparam logic [6:0] OP_VLOAD    = 7'd7;
    localparam logic [6:0] OP_VABS     = 7'd123;

    // Bit position of each class inside the one-hot class vector
    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I_ALU   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_VEC_R   = 4'd10,
        CLS_S2V     = 4'd11,
        CLS_V2S     = 4'd12,
        CLS_VSTORE  = 4'd13,
        CLS_VLOAD   = 4'd14,
        CLS_VABS    = 4'd15
    } class_idx_e;

    // Buffer occupancy states
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    // One decoded buffer entry (the PC is stored alongside, since its width is a parameter)
    typedef struct packed {
        logic [NUM_CLASSES-1:0] cls;
        logic                   illegal;
        logic [4:0]             rd;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [2:0]             funct3;
        logic [6:0]             funct7;
    } decoded_t;

    function automatic logic [NUM_CLASSES-1:0] class_bit(input class_idx_e idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - combinational opcode-to-class decode; vector classes enabled by VECTOR_EXT_EN
module opcode_classifier
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    entry
);

    logic [NUM_CLASSES-1:0] cls_raw;
    logic                   bad;

    // Map the opcode onto exactly one class bit; unknown opcodes leave the vector empty
    always_comb begin
        cls_raw = '0;
        case (instr[6:0])
            OP_R:      cls_raw = class_bit(CLS_R);
            OP_I_ALU:  cls_raw = class_bit(CLS_I_ALU);
            OP_LOAD:   cls_raw = class_bit(CLS_LOAD);
            OP_STORE:  cls_raw = class_bit(CLS_STORE);
            OP_BRANCH: cls_raw = class_bit(CLS_BRANCH);
            OP_JAL:    cls_raw = class_bit(CLS_JAL);
            OP_JALR:   cls_raw = class_bit(CLS_JALR);
            OP_LUI:    cls_raw = class_bit(CLS_LUI);
            OP_AUIPC:  cls_raw = class_bit(CLS_AUIPC);
            OP_SYSTEM: cls_raw = class_bit(CLS_SYSTEM);
`ifdef VECTOR_EXT_EN
            OP_VEC_R:  cls_raw = class_bit(CLS_VEC_R);
            OP_S2V:    cls_raw = class_bit(CLS_S2V);
            OP_V2S:    cls_raw = class_bit(CLS_V2S);
            OP_VSTORE: cls_raw = class_bit(CLS_VSTORE);
            OP_VLOAD:  cls_raw = class_bit(CLS_VLOAD);
            OP_VABS:   cls_raw = class_bit(CLS_VABS);
`endif
            default:   cls_raw = '0;
        endcase
    end

    // Illegal entries carry no class; register fields are passed through untouched
    always_comb begin
        bad           = (cls_raw == '0) || (instr[1:0] != 2'b11);
        entry.cls     = bad ? '0 : cls_raw;
        entry.illegal = bad;
        entry.rd      = instr[11:7];
        entry.rs1     = instr[19:15];
        entry.rs2     = instr[24:20];
        entry.funct3  = instr[14:12];
        entry.funct7  = instr[31:25];
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode stage with registered output buffer and illegal counter; VECTOR_EXT_EN enables vector classes
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_class,
    output logic             out_illegal,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    decoded_t        in_entry;
    decoded_t        mem_q [DEPTH];
    logic [PC_W-1:0] pc_q  [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    occ_state_e      state_q;
    occ_state_e      state_d;
    logic            push;
    logic            pop;
    decoded_t        head;

    opcode_classifier u_classifier (
        .instr (in_instr),
        .entry (in_entry)
    );

    // Flush wins over both sides of the handshake, so neither push nor pop takes effect with it
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Occupancy state, count and pointers; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q  <= OCC_EMPTY;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Next occupancy from the push/pop pair; simultaneous push and pop leaves it unchanged
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (cnt_d == '0) begin
            state_d = OCC_EMPTY;
        end else if (cnt_d == CW'(DEPTH)) begin
            state_d = OCC_FULL;
        end else begin
            state_d = OCC_PARTIAL;
        end
    end

    // Handshake outputs depend only on registered state (and reset), never on the input side
    always_comb begin
        in_ready  = !rst && (state_q != OCC_FULL);
        out_valid = !rst && (state_q != OCC_EMPTY);
    end

    // Decoded entries are written at the tail on acceptance
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
            pc_q[wr_ptr_q]  <= in_pc;
        end
    end

    // Count accepted illegal entries, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (push && in_entry.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    // Head entry drives the outputs; zeroed whenever nothing valid is presented
    always_comb begin
        head        = mem_q[rd_ptr_q];
        out_class   = out_valid ? head.cls     : '0;
        out_illegal = out_valid ? head.illegal : 1'b0;
        out_rd      = out_valid ? head.rd      : '0;
        out_rs1     = out_valid ? head.rs1     : '0;
        out_rs2     = out_valid ? head.rs2     : '0;
        out_funct3  = out_valid ? head.funct3  : '0;
        out_funct7  = out_valid ? head.funct7  : '0;
        out_pc      = out_valid ? pc_q[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed self-checking bench for instr_decode_stage
module tb_instr_decode_stage;

    localparam int PC_W  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_class;
    logic             out_illegal;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [2:0]       out_funct3;
    logic [6:0]       out_funct7;
    logic [PC_W-1:0]  out_pc;
    logic [CNT_W-1:0] illegal_cnt;

    int vectors;
    int miscompares;
    int exp_cnt;

    instr_decode_stage #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_class   (out_class),
        .out_illegal (out_illegal),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_pc      (out_pc),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_cnt();
        if (exp_cnt != 3) exp_cnt++;
    endtask

    logic [31:0] tbl_instr [8];
    logic [15:0] tbl_class [8];

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_pc       = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        tbl_instr[0] = 32'h0000006F; tbl_class[0] = 16'h0020;
        tbl_instr[1] = 32'h000000B7; tbl_class[1] = 16'h0080;
        tbl_instr[2] = 32'h00000073; tbl_class[2] = 16'h0200;
        tbl_instr[3] = 32'h00112023; tbl_class[3] = 16'h0008;
        tbl_instr[4] = 32'h00000063; tbl_class[4] = 16'h0010;
        tbl_instr[5] = 32'h00000067; tbl_class[5] = 16'h0040;
        tbl_instr[6] = 32'h00000017; tbl_class[6] = 16'h0100;
        tbl_instr[7] = 32'h003100B1; tbl_class[7] = 16'h0000;

        // Reset state
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cnt", illegal_cnt, 0);
        chk("rst_rd", out_rd, 0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // Single add: one cycle latency, field extraction, hold under backpressure
        in_valid = 1'b1;
        in_instr = 32'h003100B3;
        in_pc    = 32'h100;
        #1;
        chk("add_no_comb_path", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_class", out_class, 16'h0001);
        chk("add_rd", out_rd, 1);
        chk("add_rs1", out_rs1, 2);
        chk("add_rs2", out_rs2, 3);
        chk("add_pc", out_pc, 32'h100);
        chk("add_illegal", out_illegal, 0);
        step();
        chk("hold_valid", out_valid, 1);
        chk("hold_rd", out_rd, 1);
        out_ready = 1'b1;
        step();
        chk("add_popped", out_valid, 0);

        // Back-to-back I-ALU then load, streaming
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        step();
        chk("b2b_first_class", out_class, 16'h0002);
        chk("b2b_first_rd", out_rd, 1);
        in_instr = 32'h00012103;
        step();
        in_valid = 1'b0;
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_class", out_class, 16'h0004);
        chk("b2b_second_rd", out_rd, 2);
        step();
        chk("b2b_drained", out_valid, 0);

        // Fill to DEPTH with backpressure, no bypass when full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013;
        in_pc     = 32'h200;
        step();
        chk("fill_partial_ready", in_ready, 1);
        in_pc = 32'h204;
        step();
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        chk("full_head_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        #1;
        chk("full_no_bypass", in_ready, 0);
        step();
        chk("after_pop_in_ready", in_ready, 1);
        chk("order_pc", out_pc, 32'h204);
        step();
        chk("fill_drained", out_valid, 0);

        // Opcode 11: vector class or illegal depending on build
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000000B;
        step();
        in_valid = 1'b0;
`ifdef VECTOR_EXT_EN
        chk("op11_class", out_class, 16'h0400);
        chk("op11_illegal", out_illegal, 0);
`else
        bump_cnt();
        chk("op11_class", out_class, 16'h0000);
        chk("op11_illegal", out_illegal, 1);
`endif
        chk("op11_cnt", illegal_cnt, exp_cnt);
        out_ready = 1'b1;
        step();

        // Class table, including a bad low-bit encoding
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = tbl_instr[i];
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl_class_%0d", i), out_class, tbl_class[i]);
            chk($sformatf("tbl_illegal_%0d", i), out_illegal, (tbl_class[i] == 16'h0000));
            if (tbl_class[i] == 16'h0000) bump_cnt();
            step();
        end
        chk("tbl_cnt", illegal_cnt, exp_cnt);

        // Flush with full buffer and same-cycle input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013;
        step();
        step();
        in_instr = 32'h00000000;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_valid", out_valid, 0);
        chk("flush_full_cnt", illegal_cnt, exp_cnt);

        // Flush with partial buffer so the illegal input would otherwise be accepted
        in_valid = 1'b1;
        in_instr = 32'h00000013;
        step();
        in_instr = 32'h00000000;
        flush    = 1'b1;
        #1;
        chk("flush_part_ready", in_ready, 1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_part_valid", out_valid, 0);
        chk("flush_part_cnt", illegal_cnt, exp_cnt);

        // Mid-operation reset discards entries and accepts nothing
        in_valid = 1'b1;
        in_instr = 32'h00000013;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_cnt  = 0;
        #1;
        chk("midrst_empty", out_valid, 0);
        chk("midrst_cnt", illegal_cnt, 0);

        // Five illegal entries saturate a 2-bit counter
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00000000;
        for (int i = 0; i < 5; i++) begin
            step();
            bump_cnt();
        end
        in_valid = 1'b0;
        chk("sat_cnt", illegal_cnt, exp_cnt);
        chk("sat_cnt_abs", illegal_cnt, 3);
        rst = 1'b1;
        step();
        chk("sat_rst_cnt", illegal_cnt, 0);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, decoded-entry buffer depth; legal values are powers of two >= 2.
REQ-003 SHALL have parameter CNT_W, default 16, illegal-counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32, in_pc input PC_W as the upstream handshake, instruction and PC.
REQ-007 SHALL have port flush  input  1  discard all buffered and same-cycle input.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1 as the downstream handshake.
REQ-009 SHALL have outputs out_class (16, one-hot class), out_illegal (1), out_rd/out_rs1/out_rs2 (5 each), out_funct3 (3), out_funct7 (7) and out_pc (PC_W).
REQ-010 SHALL have output illegal_cnt  CNT_W  count of accepted illegal instructions.

Function
REQ-011 SHALL assign class bits by opcode: 0 R=51, 1 I-ALU=19, 2 load=3, 3 store=35, 4 branch=99, 5 jal=111, 6 jalr=103, 7 lui=55, 8 auipc=23, 9 transfer/system=115.
REQ-012 SHALL assign vector class bits by opcode: 10 vector_r=11, 11 scalar_to_vector=43, 12 vector_to_scalar=91, 13 store_vector=39, 14 load_vector=7, 15 vector_absolute=123.
REQ-013 SHALL mark an instruction illegal, with out_class all zero, when its opcode is unlisted or instr[1:0] != 2'b11.
REQ-014 SHALL take rd=[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12] and funct7=[31:25] unconditionally, regardless of class.
REQ-015 SHALL accept an input on a cycle where in_valid and in_ready are both 1; the decoded entry is written to the buffer on that edge.
REQ-016 SHALL have a latency of 1 cycle: out_valid rises no earlier than the cycle after acceptance, with no combinational input-to-output path.
REQ-017 SHALL pop the head entry on a cycle where out_valid and out_ready are both 1; entries leave in acceptance order.
REQ-018 SHALL drive in_ready = !full, and SHALL NOT bypass when full, even if a pop occurs the same cycle.
REQ-019 SHALL allow push and pop together when the buffer is partially full, leaving occupancy unchanged.
REQ-020 SHALL track occupancy states EMPTY, PARTIAL and FULL; pointers wrap modulo DEPTH.
REQ-021 SHALL give flush priority: the buffer is empty the next cycle, the same-cycle input is dropped and illegal_cnt is not incremented for it.
REQ-022 SHALL increment illegal_cnt once per accepted illegal entry and saturate it at all-ones.
REQ-023 SHALL hold all out_* fields stable while out_valid=1 and out_ready=0.

Reset
REQ-024 SHALL force, while rst=1: buffer EMPTY, out_valid=0, in_ready=0, illegal_cnt=0, out_* data=0.
REQ-025 SHALL raise in_ready on the first cycle after rst deasserts.
REQ-026 SHALL discard all entries on a mid-operation reset and accept nothing during reset.

Configuration
REQ-027 SHALL decode opcodes 11/43/91/39/7/123 into bits 10-15 when VECTOR_EXT_EN is defined.
REQ-028 SHALL treat those opcodes as illegal when VECTOR_EXT_EN is undefined, with bits 10-15 tied to 0.

Structure
REQ-029 SHALL place opcode constants, the class-index enum and the decoded-entry struct in shared package decode_pkg.
REQ-030 SHALL place the combinational opcode-to-class logic in sub-module opcode_classifier, instantiated once at the buffer input.

Verification
REQ-031 SHALL check: push 0x003100B3 (add) -> next cycle out_valid=1, out_class[0]=1, rd=1, rs1=2, rs2=3.
REQ-032 SHALL check: push opcodes 19 then 3 back-to-back with out_ready=1 -> class bits 1 then 2 in order, one per cycle.
REQ-033 SHALL check: out_ready=0, push DEPTH entries -> in_ready=0; raise out_ready -> in_ready=1 the cycle after the first pop.
REQ-034 SHALL check: push opcode 11 with and without VECTOR_EXT_EN -> class bit 10 vs out_illegal=1 with illegal_cnt=1.
REQ-035 SHALL check: 2 buffered entries plus flush with in_valid=1 -> next cycle out_valid=0, illegal_cnt unchanged.
REQ-036 SHALL check: CNT_W=2, push 5 illegal instructions (0x00000000) -> illegal_cnt=3; assert rst -> 0.
